pipe_stage_reg: RTL

Parametrised, flow-controlled pipeline stage register; the next generation of the fixed ID/EX latch. It carries a payload, a control word and a destination register number between any two pipeline stages, with valid/ready backpressure replacing the global `load` and a flush that inserts a zero-control bubble. An optional second (skid) entry decouples `in_ready` from `out_ready` so stalls do not form a combinational path across the pipeline.

---
 rtl/lc3b_types.sv | 12 +
 rtl/pipe_stage_entry.sv | 37 +++
 rtl/pipe_stage_reg.sv | 107 ++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b pipeline types: control-word width and stage occupancy states
package lc3b_types;
  localparam int LC3B_CTRL_W = 44;

  typedef logic [LC3B_CTRL_W-1:0] lc3b_control_word;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;
endpackage

// File: rtl/pipe_stage_entry.sv
// rtl/pipe_stage_entry.sv - one {data, ctrl, dest, valid} holding register with load and clear
// clear wins over load; clearing zeroes ctrl/dest so an empty entry reads as a NOP, data is kept.
module pipe_stage_entry #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 44,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CTRL_W-1:0] wr_ctrl,
  input  logic [DEST_W-1:0] wr_dest,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DEST_W-1:0] dest,
  output logic              valid
);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data  <= '0;
      ctrl  <= '0;
      dest  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      ctrl  <= '0;
      dest  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= wr_data;
      ctrl  <= wr_ctrl;
      dest  <= wr_dest;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - flow-controlled pipeline stage register with flush bubble
// Defining PIPE_STAGE_SKID_EN adds a skid entry and makes in_ready registered.
module pipe_stage_reg
  import lc3b_types::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = LC3B_CTRL_W,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DEST_W-1:0] out_dest
);
  pipe_state_t       state;
  logic              xfer_in;
  logic              xfer_out;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_wr_data;
  logic [CTRL_W-1:0] main_wr_ctrl;
  logic [DEST_W-1:0] main_wr_dest;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_load;
  logic              skid_clear;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DEST_W-1:0] skid_dest;

  // skid_valid is a flop output, so stalls never ripple combinationally upstream
  assign in_ready     = !skid_valid;
  assign skid_load    = !flush && (state == ONE) && xfer_in && !xfer_out;
  assign skid_clear   = flush || ((state == TWO) && xfer_out);
  assign main_load    = !flush && (((state == EMPTY) && xfer_in) ||
                                   ((state == ONE) && xfer_in && xfer_out) ||
                                   ((state == TWO) && xfer_out));
  assign main_wr_data = (state == TWO) ? skid_data : in_data;
  assign main_wr_ctrl = (state == TWO) ? skid_ctrl : in_ctrl;
  assign main_wr_dest = (state == TWO) ? skid_dest : in_dest;

  pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEST_W(DEST_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .wr_data (in_data),
    .wr_ctrl (in_ctrl),
    .wr_dest (in_dest),
    .data    (skid_data),
    .ctrl    (skid_ctrl),
    .dest    (skid_dest),
    .valid   (skid_valid)
  );
`else
  assign in_ready     = !out_valid || out_ready;
  assign main_load    = !flush && xfer_in;
  assign main_wr_data = in_data;
  assign main_wr_ctrl = in_ctrl;
  assign main_wr_dest = in_dest;
`endif

  assign main_clear = flush || ((state == ONE) && xfer_out && !xfer_in);

  pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEST_W(DEST_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (main_clear),
    .wr_data (main_wr_data),
    .wr_ctrl (main_wr_ctrl),
    .wr_dest (main_wr_dest),
    .data    (out_data),
    .ctrl    (out_ctrl),
    .dest    (out_dest),
    .valid   (out_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (xfer_in) state <= ONE;
        ONE: begin
          if (xfer_in && !xfer_out)      state <= TWO;
          else if (xfer_out && !xfer_in) state <= EMPTY;
        end
        TWO: if (xfer_out) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end
endmodule
